// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared screen geometry, pixel widths and draw FSM states
// Purpose: common constants and the draw sequencer state type.
// Ports: none (package).
package vga_pkg;

  localparam int H_RES       = 320;
  localparam int V_RES       = 240;
  localparam int ROM_LATENCY = 2;
  localparam int ADDR_W      = 17;
  localparam int COLOR_W     = 3;
  localparam int X_W         = 9;
  localparam int Y_W         = 8;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VS,
    BLIT,
    DRAIN,
    BOX,
    DONE
  } drawState_t;

endpackage

// File: rtl/pixel_delay_pipe.sv
// rtl/pixel_delay_pipe.sv - DEPTH-stage shift register carrying {valid,x,y}
// Purpose: keeps pixel coordinates aligned with synchronous ROM read data.
// Ports:
//   clk, iResetn      clock, synchronous active-low reset
//   iValid, iX, iY    coordinate of the address issued this cycle
//   oValid, oX, oY    same coordinate, DEPTH cycles later
module pixel_delay_pipe #(
  parameter int DEPTH = 2,
  parameter int X_W   = 9,
  parameter int Y_W   = 8
) (
  input  logic           clk,
  input  logic           iResetn,
  input  logic           iValid,
  input  logic [X_W-1:0] iX,
  input  logic [Y_W-1:0] iY,
  output logic           oValid,
  output logic [X_W-1:0] oX,
  output logic [Y_W-1:0] oY
);

  localparam int W = 1 + X_W + Y_W;

  logic [W-1:0] stages [DEPTH];

  always_ff @(posedge clk) begin
    if (!iResetn) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= {iValid, iX, iY};
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign {oValid, oX, oY} = stages[DEPTH-1];

endmodule

// File: rtl/fb_draw_sequencer.sv
// rtl/fb_draw_sequencer.sv - vsync-aligned background blit plus rectangle overlay
// Purpose: owns the VGA adapter write port; on request waits for a vsync
//   falling edge, copies the mode-selected ROM image, then draws an optional box.
// Ports:
//   clk, iResetn                 clock, synchronous active-low reset
//   iGameMode, iRedraw           image select; a change or a pulse requests a redraw
//   iVSync                       active-low vertical sync (clk domain)
//   iBoxEn, iBoxX0/X1/Y0/Y1      overlay rectangle, inclusive bounds
//   iBoxColor                    overlay colour
//   oRomAddr, oRomSel, iRomQ     image ROM read port
//   oX, oY, oColor, oWriteEn     adapter plot port
//   oBusy, oFrameDone            status
module fb_draw_sequencer
  import vga_pkg::*;
#(
  parameter int H_RES       = vga_pkg::H_RES,
  parameter int V_RES       = vga_pkg::V_RES,
  parameter int ROM_LATENCY = vga_pkg::ROM_LATENCY,
  parameter int ADDR_W      = vga_pkg::ADDR_W,
  parameter int COLOR_W     = vga_pkg::COLOR_W
) (
  input  logic               clk,
  input  logic               iResetn,
  input  logic [1:0]         iGameMode,
  input  logic               iVSync,
  input  logic               iRedraw,
  input  logic               iBoxEn,
  input  logic [X_W-1:0]     iBoxX0,
  input  logic [X_W-1:0]     iBoxX1,
  input  logic [Y_W-1:0]     iBoxY0,
  input  logic [Y_W-1:0]     iBoxY1,
  input  logic [COLOR_W-1:0] iBoxColor,
  output logic [ADDR_W-1:0]  oRomAddr,
  output logic [1:0]         oRomSel,
  input  logic [COLOR_W-1:0] iRomQ,
  output logic [X_W-1:0]     oX,
  output logic [Y_W-1:0]     oY,
  output logic [COLOR_W-1:0] oColor,
  output logic               oWriteEn,
  output logic               oBusy,
  output logic               oFrameDone
);

  localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);
  localparam int DCW = $clog2(ROM_LATENCY + 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(ROM_LATENCY);

  drawState_t state, stateNext;

  logic               pending, vsHist;
  logic [1:0]         lastMode;
  logic               issueValid;
  logic [X_W-1:0]     issueX, boxX0L, boxX1L, boxXCur, boxX;
  logic [Y_W-1:0]     issueY, boxY0L, boxY1L, boxYCur, boxY;
  logic               boxEnL, boxWe;
  logic [COLOR_W-1:0] boxColorL;
  logic [DCW-1:0]     drainCnt;
  logic               pipeValid;
  logic [X_W-1:0]     pipeX;
  logic [Y_W-1:0]     pipeY;

  logic vsFall, issueLast, boxLast, boxLegal, drainDone;

  assign vsFall    = vsHist & ~iVSync;
  assign issueLast = (issueX == X_LAST) && (issueY == Y_LAST);
  assign boxLast   = (boxXCur == boxX1L) && (boxYCur == boxY1L);
  assign drainDone = (drainCnt == DRAIN_LAST);
  assign boxLegal  = boxEnL && (boxX0L <= boxX1L) && (boxX1L <= X_LAST) &&
                     (boxY0L <= boxY1L) && (boxY1L <= Y_LAST);

  always_ff @(posedge clk) begin
    if (!iResetn) state <= IDLE;
    else          state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (pending) stateNext = WAIT_VS;
      WAIT_VS: if (vsFall) stateNext = BLIT;
      BLIT:    if (issueLast) stateNext = DRAIN;
      DRAIN:   if (drainDone) stateNext = boxLegal ? BOX : DONE;
      BOX:     if (boxLast) stateNext = DONE;
      DONE:    stateNext = pending ? WAIT_VS : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!iResetn) begin
      pending    <= 1'b0;
      vsHist     <= 1'b1;
      lastMode   <= '0;
      oRomAddr   <= '0;
      oRomSel    <= '0;
      issueValid <= 1'b0;
      issueX     <= '0;
      issueY     <= '0;
      boxEnL     <= 1'b0;
      boxX0L     <= '0;
      boxX1L     <= '0;
      boxY0L     <= '0;
      boxY1L     <= '0;
      boxColorL  <= '0;
      boxXCur    <= '0;
      boxYCur    <= '0;
      boxWe      <= 1'b0;
      boxX       <= '0;
      boxY       <= '0;
      drainCnt   <= '0;
      oBusy      <= 1'b0;
      oFrameDone <= 1'b0;
    end else begin
      vsHist     <= iVSync;
      lastMode   <= iGameMode;
      oBusy      <= (stateNext != IDLE);
      oFrameDone <= (state == DONE);
      boxWe      <= 1'b0;
      // A new request wins over the clear so a request landing on the
      // frame-start cycle is carried into the next frame.
      if (iRedraw || (iGameMode != lastMode)) pending <= 1'b1;
      else if (state == WAIT_VS && vsFall)    pending <= 1'b0;

      case (state)
        WAIT_VS: if (vsFall) begin
          oRomSel    <= iGameMode;
          boxEnL     <= iBoxEn;
          boxX0L     <= iBoxX0;
          boxX1L     <= iBoxX1;
          boxY0L     <= iBoxY0;
          boxY1L     <= iBoxY1;
          boxColorL  <= iBoxColor;
          oRomAddr   <= '0;
          issueX     <= '0;
          issueY     <= '0;
          issueValid <= 1'b1;
        end
        BLIT: begin
          if (issueLast) begin
            issueValid <= 1'b0;
            drainCnt   <= '0;
          end else begin
            oRomAddr <= oRomAddr + ADDR_W'(1);
            if (issueX == X_LAST) begin
              issueX <= '0;
              issueY <= issueY + Y_W'(1);
            end else begin
              issueX <= issueX + X_W'(1);
            end
          end
        end
        DRAIN: begin
          drainCnt <= drainCnt + DCW'(1);
          boxXCur  <= boxX0L;
          boxYCur  <= boxY0L;
        end
        BOX: begin
          boxWe <= 1'b1;
          boxX  <= boxXCur;
          boxY  <= boxYCur;
          if (boxXCur == boxX1L) begin
            boxXCur <= boxX0L;
            boxYCur <= boxYCur + Y_W'(1);
          end else begin
            boxXCur <= boxXCur + X_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  pixel_delay_pipe #(
    .DEPTH (ROM_LATENCY),
    .X_W   (X_W),
    .Y_W   (Y_W)
  ) uPipe (
    .clk     (clk),
    .iResetn (iResetn),
    .iValid  (issueValid),
    .iX      (issueX),
    .iY      (issueY),
    .oValid  (pipeValid),
    .oX      (pipeX),
    .oY      (pipeY)
  );

  // Blit and box phases never overlap, so the plot port is a plain select of
  // two register sets. ROM data passes straight through: the ROM output is
  // itself registered and aligned with the delayed coordinate.
  assign oWriteEn = pipeValid | boxWe;
  assign oX       = boxWe ? boxX : pipeX;
  assign oY       = boxWe ? boxY : pipeY;
  assign oColor   = boxWe ? boxColorL : (pipeValid ? iRomQ : '0);

endmodule

// File: tb/tb_fb_draw_sequencer.sv
// tb/tb_fb_draw_sequencer.sv - scoreboard bench for fb_draw_sequencer
module tb_fb_draw_sequencer;

  localparam int H = 8;
  localparam int V = 4;
  localparam int L = 2;

  logic        clk = 1'b0;
  logic        iResetn = 1'b0;
  logic [1:0]  iGameMode = '0;
  logic        iVSync = 1'b1;
  logic        iRedraw = 1'b0;
  logic        iBoxEn = 1'b0;
  logic [8:0]  iBoxX0 = '0, iBoxX1 = '0;
  logic [7:0]  iBoxY0 = '0, iBoxY1 = '0;
  logic [2:0]  iBoxColor = '0;
  logic [16:0] oRomAddr;
  logic [1:0]  oRomSel;
  logic [2:0]  iRomQ = '0, rq1 = '0;
  logic [8:0]  oX;
  logic [7:0]  oY;
  logic [2:0]  oColor;
  logic        oWriteEn, oBusy, oFrameDone;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wrCount = 0, firstWr = -1, lastWr = -1, doneCount = 0, doneCyc = -1;
  logic [19:0] sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fb_draw_sequencer #(
    .H_RES(H), .V_RES(V), .ROM_LATENCY(L), .ADDR_W(17), .COLOR_W(3)
  ) dut (
    .clk(clk), .iResetn(iResetn), .iGameMode(iGameMode), .iVSync(iVSync),
    .iRedraw(iRedraw), .iBoxEn(iBoxEn), .iBoxX0(iBoxX0), .iBoxX1(iBoxX1),
    .iBoxY0(iBoxY0), .iBoxY1(iBoxY1), .iBoxColor(iBoxColor),
    .oRomAddr(oRomAddr), .oRomSel(oRomSel), .iRomQ(iRomQ),
    .oX(oX), .oY(oY), .oColor(oColor), .oWriteEn(oWriteEn),
    .oBusy(oBusy), .oFrameDone(oFrameDone)
  );

  function automatic logic [2:0] romModel(input logic [1:0] sel, input int addr);
    int v;
    v = addr * 5 + int'(sel) * 3 + 1;
    return v[2:0];
  endfunction

  // Two-cycle synchronous ROM.
  always @(posedge clk) begin
    rq1   <= romModel(oRomSel, int'(oRomAddr));
    iRomQ <= rq1;
  end

  // Write monitor: every plot strobe is compared against the scoreboard.
  always @(negedge clk) begin
    if (oWriteEn) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected cyc=%0d got x=%0d y=%0d c=%0d required no write", cyc, oX, oY, oColor);
      end else begin
        logic [19:0] e;
        e = sb.pop_front();
        if ({oX, oY, oColor} !== e) begin
          errors++;
          $display("FAIL write_pixel cyc=%0d got x=%0d y=%0d c=%0d required x=%0d y=%0d c=%0d",
                   cyc, oX, oY, oColor, e[19:11], e[10:3], e[2:0]);
        end
      end
      if (firstWr < 0) firstWr = cyc;
      lastWr = cyc;
      wrCount++;
    end
    if (oFrameDone) begin
      doneCount++;
      doneCyc = cyc;
    end
  end

  task automatic clearStats();
    wrCount = 0; firstWr = -1; lastWr = -1; doneCount = 0; doneCyc = -1;
  endtask

  task automatic pushBlit(input logic [1:0] sel);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        sb.push_back({9'(x), 8'(y), romModel(sel, y * H + x)});
  endtask

  task automatic pushBox(input int x0, input int x1, input int y0, input int y1, input logic [2:0] c);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        sb.push_back({9'(x), 8'(y), c});
  endtask

  // Request a redraw, then drop vsync; returns the cycle index p of the
  // clock edge that samples the falling edge. Returns at the negedge after p.
  task automatic startFrame(output int p);
    @(negedge clk); iRedraw = 1'b1;
    @(negedge clk); iRedraw = 1'b0;
    repeat (2) @(negedge clk);
    iVSync = 1'b0;
    p = cyc + 1;
    @(negedge clk);
    iVSync = 1'b1;
  endtask

  task automatic waitDone(input int target);
    for (int k = 0; k < 300 && doneCount < target; k++) @(negedge clk);
  endtask

  task automatic test_reset();
    bit busySeen;
    iResetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({oWriteEn, oBusy, oFrameDone, oRomAddr, oRomSel, oX, oY, oColor} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got we=%0b busy=%0b done=%0b addr=%0d sel=%0d x=%0d y=%0d c=%0d required all 0",
               oWriteEn, oBusy, oFrameDone, oRomAddr, oRomSel, oX, oY, oColor);
    end
    iResetn = 1'b1;
    clearStats();
    busySeen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      iVSync = ~iVSync;
      if (oBusy) busySeen = 1;
    end
    iVSync = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (busySeen || wrCount != 0 || doneCount != 0) begin
      errors++;
      $display("FAIL idle_quiet got busy=%0b writes=%0d done=%0d required 0 0 0", busySeen, wrCount, doneCount);
    end
  endtask

  task automatic test_blit();
    int p;
    clearStats();
    pushBlit(2'd0);
    startFrame(p);
    checks++;
    if (oRomAddr !== 17'd0 || oRomSel !== 2'd0 || oBusy !== 1'b1) begin
      errors++;
      $display("FAIL blit_start got addr=%0d sel=%0d busy=%0b required 0 0 1", oRomAddr, oRomSel, oBusy);
    end
    for (int i = 1; i < H * V; i++) begin
      @(negedge clk);
      if (i == 12) iVSync = 1'b0;
      if (i == 14) iVSync = 1'b1;
      checks++;
      if (oRomAddr !== 17'(i)) begin
        errors++;
        $display("FAIL blit_addr cyc=%0d got %0d required %0d", cyc, oRomAddr, i);
      end
    end
    waitDone(1);
    repeat (3) @(negedge clk);
    checks++;
    if (doneCount != 1 || doneCyc != p + 36) begin
      errors++;
      $display("FAIL blit_done got count=%0d cyc=%0d required 1 %0d", doneCount, doneCyc, p + 36);
    end
    checks++;
    if (wrCount != 32 || firstWr != p + 2 || lastWr != p + 33) begin
      errors++;
      $display("FAIL blit_writes got n=%0d first=%0d last=%0d required 32 %0d %0d", wrCount, firstWr, lastWr, p + 2, p + 33);
    end
    checks++;
    if (sb.size() != 0 || oWriteEn !== 1'b0 || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL blit_end got left=%0d we=%0b busy=%0b required 0 0 0", sb.size(), oWriteEn, oBusy);
    end
    sb.delete();
  endtask

  task automatic test_box();
    int p;
    clearStats();
    iBoxEn = 1'b1; iBoxX0 = 9'd2; iBoxX1 = 9'd3; iBoxY0 = 8'd1; iBoxY1 = 8'd2; iBoxColor = 3'd5;
    pushBlit(2'd0);
    pushBox(2, 3, 1, 2, 3'd5);
    startFrame(p);
    // Box inputs change mid-frame; the latched copy must be used.
    iBoxColor = 3'd1; iBoxX1 = 9'd6;
    waitDone(1);
    repeat (3) @(negedge clk);
    checks++;
    if (wrCount != 36 || doneCount != 1 || doneCyc != p + 40 || lastWr != p + 39) begin
      errors++;
      $display("FAIL box_frame got n=%0d done=%0d dcyc=%0d last=%0d required 36 1 %0d %0d",
               wrCount, doneCount, doneCyc, lastWr, p + 40, p + 39);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL box_left got %0d required 0", sb.size());
    end
    sb.delete();
    iBoxEn = 1'b0;
  endtask

  task automatic test_illegal_box();
    int p;
    for (int v = 0; v < 2; v++) begin
      clearStats();
      iBoxEn = 1'b1; iBoxY0 = 8'd0; iBoxY1 = 8'd1; iBoxColor = 3'd7;
      if (v == 0) begin iBoxX0 = 9'd5; iBoxX1 = 9'd3; end
      else        begin iBoxX0 = 9'd2; iBoxX1 = 9'd8; end
      pushBlit(2'd0);
      startFrame(p);
      waitDone(1);
      repeat (6) @(negedge clk);
      checks++;
      if (wrCount != 32 || doneCount != 1 || doneCyc != p + 36 || sb.size() != 0) begin
        errors++;
        $display("FAIL illegal_box%0d got n=%0d done=%0d dcyc=%0d left=%0d required 32 1 %0d 0",
                 v, wrCount, doneCount, doneCyc, sb.size(), p + 36);
      end
      sb.delete();
    end
    iBoxEn = 1'b0;
  endtask

  task automatic test_mode_change();
    int p, p2;
    clearStats();
    pushBlit(2'd0);
    startFrame(p);
    repeat (10) @(negedge clk);
    iGameMode = 2'd2; iRedraw = 1'b1;
    @(negedge clk); iRedraw = 1'b0;
    checks++;
    if (oRomSel !== 2'd0) begin
      errors++;
      $display("FAIL mode_hold got sel=%0d required 0", oRomSel);
    end
    waitDone(1);
    repeat (4) @(negedge clk);
    checks++;
    if (doneCount != 1 || doneCyc != p + 36 || oBusy !== 1'b1 || wrCount != 32) begin
      errors++;
      $display("FAIL mode_first got done=%0d dcyc=%0d busy=%0b n=%0d required 1 %0d 1 32",
               doneCount, doneCyc, oBusy, wrCount, p + 36);
    end
    pushBlit(2'd2);
    iVSync = 1'b0;
    p2 = cyc + 1;
    @(negedge clk);
    iVSync = 1'b1;
    checks++;
    if (oRomSel !== 2'd2 || oRomAddr !== 17'd0) begin
      errors++;
      $display("FAIL mode_second_start got sel=%0d addr=%0d required 2 0", oRomSel, oRomAddr);
    end
    waitDone(2);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      iVSync = ~iVSync;
    end
    iVSync = 1'b1;
    checks++;
    if (doneCount != 2 || doneCyc != p2 + 36 || wrCount != 64 || sb.size() != 0) begin
      errors++;
      $display("FAIL mode_second got done=%0d dcyc=%0d n=%0d left=%0d required 2 %0d 64 0",
               doneCount, doneCyc, wrCount, sb.size(), p2 + 36);
    end
    sb.delete();
  endtask

  task automatic test_reset_mid();
    int p;
    @(negedge clk);
    iResetn = 1'b0; iGameMode = 2'd0;
    repeat (2) @(negedge clk);
    iResetn = 1'b1;
    clearStats();
    pushBlit(2'd0);
    startFrame(p);
    for (int k = 0; k < 100 && wrCount < 10; k++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (wrCount != 10) begin
      errors++;
      $display("FAIL reset_mid_reach got %0d writes required 10", wrCount);
    end
    iResetn = 1'b0;
    sb.delete();
    @(negedge clk);
    checks++;
    if (oWriteEn !== 1'b0 || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_abort got we=%0b busy=%0b required 0 0", oWriteEn, oBusy);
    end
    @(negedge clk);
    iResetn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      iVSync = ~iVSync;
    end
    iVSync = 1'b1;
    checks++;
    if (wrCount != 10 || doneCount != 0 || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_quiet got n=%0d done=%0d busy=%0b required 10 0 0", wrCount, doneCount, oBusy);
    end
  endtask

  initial begin
    test_reset();
    test_blit();
    test_box();
    test_illegal_box();
    test_mode_change();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
